// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller:
// nibble width, scan FSM states and the digit-enable one-hot helper.
package seg7_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int MAX_DIGITS = 8;

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } scan_state_t;

  // Index is sized for the largest supported display; callers truncate.
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] index);
    logic [MAX_DIGITS-1:0] vec;
    vec        = '0;
    vec[index] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Load handshake between the value producer and the scan controller's
// shadow buffer.
interface seg7_scan_ctrl_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                           load_valid;
  logic                           load_ready;
  logic [NIBBLE_W*NUM_DIGITS-1:0] load_value;

  modport master (
    output load_valid,
    output load_value,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_value,
    output load_ready
  );

endinterface

// File: rtl/seg7_lz_mask.sv
// Leading-zero mask: bit i is set when digit i and every digit above it
// are zero. Digit 0 is never masked so a zero value still shows "0".
module seg7_lz_mask
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]          lz_mask
);

  logic [NUM_DIGITS-1:0] nib_nz;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nz
      assign nib_nz[gi] = |value[gi*NIBBLE_W +: NIBBLE_W];
    end
  endgenerate

  // Walk from the most significant digit down, remembering whether any
  // non-zero digit has been seen yet.
  always_comb begin
    logic seen_nz;
    seen_nz = 1'b0;
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen_nz    = seen_nz | nib_nz[i];
      lz_mask[i] = (i != 0) && !seen_nz;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display,
// with a shadow buffer committed only at frame boundaries.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_WIDTH    = 16,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIV_WIDTH-1:0]  scan_div,
  input  logic                  lz_blank_en,
  seg7_scan_ctrl_if.slave       load_if,
  output logic [NIBBLE_W-1:0]   digit_nibble,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  digit_blank,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int GAP_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam int CNT_W = (DIV_WIDTH > GAP_W) ? DIV_WIDTH : GAP_W;
  localparam int BUF_W = NIBBLE_W * NUM_DIGITS;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  scan_state_t       state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next, idx_inc;
  logic [CNT_W-1:0]  cnt_reg, cnt_next, dwell;
  logic              run_reg;
  logic [BUF_W-1:0]  active_reg, active_next, shadow_reg;
  logic              shadow_full_reg;
  logic              frame_bnd, load_fire, commit;

  logic [NIBBLE_W-1:0]   nib_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_mask;

  assign dwell   = (scan_div == '0) ? CNT_ONE : CNT_W'(scan_div);
  assign idx_inc = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);

  assign frame_bnd = run_reg && (state_reg == SHOW) &&
                     (idx_reg == LAST_IDX) && (cnt_reg == CNT_ONE);
  assign commit    = frame_bnd && shadow_full_reg;
  assign load_fire = load_if.load_valid && !shadow_full_reg;

  assign load_if.load_ready = !shadow_full_reg;

  // Outputs are registered from next-state values, so they must see the
  // buffer contents that will be active in the cycle they are displayed.
  assign active_next = commit ? shadow_reg : active_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign nib_arr[gi] = active_next[gi*NIBBLE_W +: NIBBLE_W];
    end
  endgenerate

  seg7_lz_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lz_mask (
    .value   (active_next),
    .lz_mask (lz_mask)
  );

  // Scan FSM. The counter holds the cycles remaining in the current
  // SHOW/GAP slot, including the present one. The first cycle after reset
  // is spent loading the output registers, so the counter waits for run_reg.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    if (run_reg) begin
      if (cnt_reg > CNT_ONE) begin
        cnt_next = cnt_reg - CNT_ONE;
      end else if ((state_reg == SHOW) && (BLANK_CYCLES > 0)) begin
        state_next = GAP;
        cnt_next   = CNT_W'(BLANK_CYCLES);
      end else begin
        state_next = SHOW;
        idx_next   = idx_inc;
        cnt_next   = dwell;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= SHOW;
      idx_reg         <= '0;
      cnt_reg         <= dwell;
      run_reg         <= 1'b0;
      active_reg      <= '0;
      shadow_reg      <= '0;
      shadow_full_reg <= 1'b0;
      digit_sel       <= '0;
      digit_nibble    <= '0;
      digit_blank     <= 1'b1;
      frame_done      <= 1'b0;
    end else begin
      run_reg    <= 1'b1;
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      cnt_reg    <= cnt_next;
      active_reg <= active_next;

      // Commit and accept are mutually exclusive: accept needs an empty
      // shadow, commit needs a full one.
      if (commit) begin
        shadow_full_reg <= 1'b0;
      end else if (load_fire) begin
        shadow_reg      <= load_if.load_value;
        shadow_full_reg <= 1'b1;
      end

      if (state_next == SHOW) begin
        digit_sel    <= NUM_DIGITS'(onehot(3'(idx_next)));
        digit_nibble <= nib_arr[idx_next];
        digit_blank  <= lz_blank_en & lz_mask[idx_next];
      end else begin
        digit_sel   <= '0;
        digit_blank <= 1'b1;
      end

      frame_done <= (state_next == SHOW) && (idx_next == LAST_IDX) &&
                    (cnt_next == CNT_ONE);
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-level model pushes expected
// display segments, a monitor collapses DUT output runs into segments.
module tb_seg7_scan_ctrl;
  import seg7_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int B  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] scan_div;
  logic          lz_blank_en;
  logic [3:0]    digit_nibble;
  logic [N-1:0]  digit_sel;
  logic          digit_blank;
  logic          frame_done;

  seg7_scan_ctrl_if #(.NUM_DIGITS(N)) load_if ();

  seg7_scan_ctrl #(
    .NUM_DIGITS   (N),
    .DIV_WIDTH    (DW),
    .BLANK_CYCLES (B)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .scan_div     (scan_div),
    .lz_blank_en  (lz_blank_en),
    .load_if      (load_if),
    .digit_nibble (digit_nibble),
    .digit_sel    (digit_sel),
    .digit_blank  (digit_blank),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] sel;
    logic [3:0]   nib;
    logic         blank;
    int           len;
    int           fd;   // 0 none, 1 single pulse on last cycle, 2 anything else
  } seg_t;

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } ev_t;

  seg_t exp_q[$];
  ev_t  ld_q[$];
  ev_t  dv_q[$];

  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;
  logic [15:0] m_act;
  logic [15:0] m_shadow;
  bit          m_full;
  bit          drv_valid;
  logic [15:0] drv_val;
  int          t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", nm, got, want);
    end
  endtask

  // ---------------- monitor ----------------
  seg_t cur;
  bit   cur_open = 1'b0;
  int   fd_cnt;
  bit   fd_last;

  task automatic close_seg();
    seg_t e;
    tests++;
    cur.fd = (fd_cnt == 0) ? 0 : ((fd_cnt == 1 && fd_last) ? 1 : 2);
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL seg_underflow got sel=%b nib=%h len=%0d with nothing expected",
               cur.sel, cur.nib, cur.len);
    end else begin
      e = exp_q.pop_front();
      if (cur.sel !== e.sel || cur.nib !== e.nib || cur.blank !== e.blank ||
          cur.len != e.len || cur.fd != e.fd) begin
        fails++;
        $display("FAIL seg got sel=%b nib=%h blank=%b len=%0d fd=%0d expected sel=%b nib=%h blank=%b len=%0d fd=%0d",
                 cur.sel, cur.nib, cur.blank, cur.len, cur.fd,
                 e.sel, e.nib, e.blank, e.len, e.fd);
      end else begin
        $display("[TB] seg sel=%b nib=%h blank=%b len=%0d fd=%0d ok",
                 cur.sel, cur.nib, cur.blank, cur.len, cur.fd);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      cur_open = 1'b0;
    end else if (cur_open && digit_sel === cur.sel && digit_nibble === cur.nib &&
                 digit_blank === cur.blank) begin
      cur.len++;
      if (frame_done) fd_cnt++;
      fd_last = frame_done;
    end else begin
      if (cur_open) close_seg();
      cur.sel   = digit_sel;
      cur.nib   = digit_nibble;
      cur.blank = digit_blank;
      cur.len   = 1;
      cur.fd    = 0;
      fd_cnt    = frame_done ? 1 : 0;
      fd_last   = frame_done;
      cur_open  = 1'b1;
    end
  end

  // ---------------- model / stimulus ----------------
  task automatic step(input bit boundary);
    ev_t ev;
    bit  accept;
    tests++;
    if (load_if.load_ready !== !m_full) begin
      fails++;
      $display("FAIL load_ready t=%0d got %b expected %b", t, load_if.load_ready, !m_full);
    end
    while (dv_q.size() > 0 && dv_q[0].cyc <= t) begin
      ev = dv_q.pop_front();
      scan_div = ev.val;
    end
    if (!drv_valid && ld_q.size() > 0 && ld_q[0].cyc <= t) begin
      ev = ld_q.pop_front();
      drv_valid = 1'b1;
      drv_val   = ev.val;
      load_if.load_valid = 1'b1;
      load_if.load_value = ev.val;
    end
    accept = drv_valid && !m_full;
    @(posedge clk); #1;
    if (boundary && m_full) begin
      m_act  = m_shadow;
      m_full = 1'b0;
    end
    if (accept) begin
      m_shadow  = drv_val;
      m_full    = 1'b1;
      drv_valid = 1'b0;
      load_if.load_valid = 1'b0;
      load_if.load_value = 16'($urandom);
      $display("[TB] load %h accepted t=%0d", drv_val, t);
    end
    t++;
  endtask

  task automatic run(input int nframes, input int stop_at);
    seg_t         s;
    int           d;
    logic [3:0]   nib;
    logic [N-1:0] one;
    bit           stop;
    one  = 1;
    stop = 1'b0;
    t    = 0;
    mon_en = 1'b1;
    for (int f = 0; f < nframes && !stop; f++) begin
      for (int i = 0; i < N && !stop; i++) begin
        if (stop_at >= 0 && t >= stop_at) stop = 1'b1;
        if (stop) break;
        d     = (scan_div == 0) ? 1 : int'(scan_div);
        nib   = m_act[4*i +: 4];
        s.sel   = one << i;
        s.nib   = nib;
        s.blank = lz_blank_en && (i != 0) && ((m_act >> (4*i)) == 16'h0);
        s.len   = d;
        s.fd    = (i == N-1) ? 1 : 0;
        exp_q.push_back(s);
        for (int c = 0; c < d; c++) begin
          if (stop_at >= 0 && t >= stop_at) stop = 1'b1;
          if (stop) break;
          step((i == N-1) && (c == d-1));
        end
        if (stop) break;
        s.sel = '0; s.nib = nib; s.blank = 1'b1; s.len = B; s.fd = 0;
        exp_q.push_back(s);
        for (int c = 0; c < B; c++) begin
          if (stop_at >= 0 && t >= stop_at) stop = 1'b1;
          if (stop) break;
          step(1'b0);
        end
      end
    end
    mon_en = 1'b0;
    chk("seg_residual", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    ld_q.delete();
    dv_q.delete();
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    load_if.load_valid = 1'b0;
    drv_valid = 1'b0;
    ld_q.delete();
    dv_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    chk("rst_sel",   32'(digit_sel), 32'd0);
    chk("rst_nib",   32'(digit_nibble), 32'd0);
    chk("rst_blank", 32'(digit_blank), 32'd1);
    chk("rst_fd",    32'(frame_done), 32'd0);
    chk("rst_ready", 32'(load_if.load_ready), 32'd1);
    @(posedge clk); #1;
    reset  = 1'b0;
    m_act  = '0;
    m_full = 1'b0;
    chk("start_ready", 32'(load_if.load_ready), 32'd1);
    chk("start_sel",   32'(digit_sel), 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] rand_val();
    logic [15:0] masks [4];
    masks[0] = 16'hffff; masks[1] = 16'h0fff; masks[2] = 16'h00ff; masks[3] = 16'h000f;
    return 16'($urandom) & masks[$urandom_range(0, 3)];
  endfunction

  initial begin
    int c;
    reset = 1'b1;
    scan_div = 16'd3;
    lz_blank_en = 1'b0;
    load_if.load_valid = 1'b0;
    load_if.load_value = '0;

    // Plain scan: 3-cycle dwell, 4-cycle gap, 28-cycle frame.
    do_reset();
    run(2, -1);

    // Single load, committed at the first frame boundary.
    do_reset();
    ld_q.push_back('{0, 16'h1234});
    run(3, -1);

    // Second load held against a full shadow.
    do_reset();
    ld_q.push_back('{0, rand_val()});
    ld_q.push_back('{2, 16'h5678});
    run(4, -1);

    // Leading-zero blanking.
    lz_blank_en = 1'b1;
    do_reset();
    ld_q.push_back('{0, 16'h0040});
    ld_q.push_back('{30, 16'h0000});
    run(3, -1);
    lz_blank_en = 1'b0;

    // Zero divider means one-cycle dwell.
    scan_div = 16'd0;
    do_reset();
    run(2, -1);

    // Divider change mid-dwell takes effect at the next digit.
    scan_div = 16'd2;
    do_reset();
    dv_q.push_back('{1, 16'd5});
    run(2, -1);

    // Reset in the gap after digit 2 with the shadow full discards it.
    scan_div = 16'd3;
    do_reset();
    ld_q.push_back('{0, 16'hbeef});
    run(1, 2*(3+B) + 3 + 1);
    do_reset();
    run(2, -1);

    // Randomized runs.
    for (int k = 0; k < 6; k++) begin
      scan_div    = 16'($urandom_range(0, 4));
      lz_blank_en = 1'($urandom_range(0, 1));
      do_reset();
      c = $urandom_range(0, 10);
      for (int j = 0; j < 3; j++) begin
        ld_q.push_back('{c, rand_val()});
        c = c + $urandom_range(0, 40);
      end
      dv_q.push_back('{$urandom_range(0, 60), 16'($urandom_range(0, 4))});
      run(4, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
